// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the song playback path.
//   NOTE_W       width of a note time (10 ms units)
//   NOTE_NONE    all-ones time; both the "no note" value and the ROM end marker
//   feed_state_t state encoding of the note_feeder fetch FSM
package song_pkg;

    localparam int NOTE_W = 18;
    localparam logic [NOTE_W-1:0] NOTE_NONE = {NOTE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } feed_state_t;

    function automatic logic is_sentinel(input logic [NOTE_W-1:0] t);
        return t == NOTE_NONE;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// note_fifo: small synchronous FIFO of note times with a fall-through head.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   flush         empty the FIFO (same effect as reset on pointers/count)
//   push, data    write data when push is high
//   pop           remove the head; ignored while empty
//   head          current head, NOTE_NONE while empty (combinational from rd_ptr)
//   count         number of stored entries, 0..DEPTH
// Handshake: push and pop are plain strobes, both may be high in one cycle,
// including when full (the pop frees the slot the push uses).
module note_fifo
    import song_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [NOTE_W-1:0]          data,
    input  logic                       pop,
    output logic [NOTE_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [NOTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !(reset || flush)) mem[wr_ptr] <= data;
    end

    assign head = (count == '0) ? NOTE_NONE : mem[rd_ptr];

endmodule

// File: rtl/note_feeder.sv
// note_feeder: walks one track of the song ROM and keeps a prefetch FIFO of
// upcoming note times for the note matcher.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   song_start     pulse: flush and restart the song from ROM address 0
//   rom_addr       registered ROM read address
//   rom_data       ROM data, valid one cycle after rom_addr (BRAM latency)
//   note_request   pulse: pop the current head note
//   note_time      head note time, NOTE_NONE when nothing is buffered
//   note_valid     FIFO non-empty
//   song_done      end of song reached and FIFO drained
//   order_error    sticky: a fetched time was lower than its predecessor
// Handshake: note_request pops only when note_valid is high; a request
// without a valid head, or coinciding with song_start, is dropped.
module note_feeder
    import song_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              song_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_data,
    input  logic              note_request,
    output logic [NOTE_W-1:0] note_time,
    output logic              note_valid,
    output logic              song_done,
    output logic              order_error
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    feed_state_t       state;
    feed_state_t       state_next;
    logic              inflight;      // a read was issued last cycle; rom_data is its result
    logic              have_last;     // at least one note pushed since song_start
    logic [NOTE_W-1:0] last_time;
    logic [CNT_W-1:0]  fifo_count;
    logic              sentinel_hit;
    logic              credit_ok;
    logic              last_addr;
    logic              issue;
    logic              push;
    logic              pop;

    assign sentinel_hit = inflight && is_sentinel(rom_data);
    // Credit: buffered entries plus the read in flight must leave room.
    assign credit_ok    = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_C;
    assign last_addr    = (rom_addr == {ADDR_W{1'b1}});

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;

        // Results of reads issued before a restart are discarded.
        if (!song_start) begin
            push = inflight && !sentinel_hit;
            pop  = note_request && note_valid;
        end

        case (state)
            ST_IDLE: ;
            ST_FETCH: begin
                // A sentinel squashes any read that would issue alongside it.
                issue = credit_ok && !sentinel_hit && !song_start;
                if (sentinel_hit)
                    state_next = ST_DRAIN;
                else if (issue && last_addr)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: ;
            default: state_next = ST_IDLE;
        endcase

        if (song_start) state_next = ST_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr    <= '0;
            inflight    <= 1'b0;
            have_last   <= 1'b0;
            last_time   <= '0;
            order_error <= 1'b0;
        end else if (song_start) begin
            rom_addr  <= '0;
            inflight  <= 1'b0;
            have_last <= 1'b0;
        end else begin
            inflight <= issue;
            // The final ROM address is read once and the address then holds.
            if (issue && !last_addr) rom_addr <= rom_addr + ADDR_W'(1);
            if (push) begin
                last_time <= rom_data;
                have_last <= 1'b1;
                if (have_last && (rom_data < last_time)) order_error <= 1'b1;
            end
        end
    end

    note_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (song_start),
        .push  (push),
        .data  (rom_data),
        .pop   (pop),
        .head  (note_time),
        .count (fifo_count)
    );

    assign note_valid = (fifo_count != '0);
    assign song_done  = (state == ST_DRAIN) && (fifo_count == '0);

endmodule

// File: doc/note_feeder.md
Name: note_feeder

Overview:
- Supplies the note matcher with the next upcoming note time for one track.
- Walks a song ROM of ascending 18-bit note times (10 ms units) and keeps a small prefetch FIFO.
- Presents the FIFO head on note_time, or all 1's when no note is buffered.
- Pops the head on each note_request pulse from the matcher. One instance per lane sits between the song BRAM and the matcher.

Parameters:
- ADDR_W, 12, song ROM address width (max 4096 entries per track).
- DEPTH, 4, prefetch FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- song_start  in  1  single-cycle pulse: restart the song from ROM address 0.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_data  in  18  ROM read data, valid the cycle after rom_addr is presented (1-cycle BRAM latency).
- note_request  in  1  single-cycle pulse: pop the current head note.
- note_time  out  18  head note time; 18'h3FFFF when the FIFO is empty.
- note_valid  out  1  FIFO non-empty.
- song_done  out  1  end-of-song reached and FIFO drained.
- order_error  out  1  sticky flag: a fetched time was less than its predecessor.

Behaviour:
- Reset values:
  - rom_addr=0, note_valid=0, note_time=18'h3FFFF, song_done=0, order_error=0.
  - FIFO empty, FSM=IDLE, no read in flight.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: no reads issued; outputs stay at their empty values. song_start -> FETCH.
  - FETCH: issue a read whenever (fifo_count + inflight) < DEPTH.
    - One new address per cycle at most; rom_addr increments after each issue.
    - The data returned one cycle later is pushed, unless it equals 18'h3FFFF (sentinel). Sentinel -> DRAIN; it is not pushed and the in-flight read is squashed.
    - Issuing the read at address 2^ADDR_W-1 also ends the song: that entry is pushed if not the sentinel, then -> DRAIN. rom_addr never wraps.
  - DRAIN: no reads issued. song_done=1 when the FIFO is empty; it stays 1 until song_start or reset.
- Latency: song_start high in cycle T -> rom_addr=0 in T+1 -> rom_data in T+2 -> pushed at the end of T+2 -> note_valid=1 and note_time=first entry in T+3.
- Pop:
  - note_request with note_valid=1 removes the head; the new head is visible the next cycle.
  - note_request with the FIFO empty is ignored, with no error.
- Simultaneous push and pop in the same cycle: both take effect and the count is unchanged. Required when the FIFO is full, since the pop frees the slot the push uses.
- song_start in any state, including mid-song:
  - Flush the FIFO, discard any in-flight read result, clear song_done, rom_addr<=0, -> FETCH.
  - order_error is NOT cleared; only reset clears it.
  - A note_request in the same cycle as song_start is ignored.
- Ordering check:
  - Compare each pushed time against the last pushed time since song_start. A lower value sets order_error.
  - The note is still pushed unmodified. Equal times are legal (chords across lanes are handled elsewhere).
- reset has priority over song_start and note_request.
- The FIFO never overflows by construction (credit count). The bench asserts count <= DEPTH.

Decomposition:
- Shared package (song_pkg):
  - NOTE_W=18.
  - NOTE_NONE=18'h3FFFF, used as both the empty value and the ROM sentinel.
  - FSM state encoding for IDLE/FETCH/DRAIN.
- Sub-module note_fifo: synchronous FIFO.
  - Parameters: DEPTH, width NOTE_W.
  - Ports: push/pop/flush, head, count.
  - Head is fall-through from the memory so note_time is combinational from the read pointer.
- FSM, credit counter and ordering check stay in note_feeder.

Test Plan:
- ROM = {100, 250, 400, NOTE_NONE}; song_start at cycle 10 -> note_valid=1 and note_time=100 at cycle 13. After three spaced pops the heads read 250, 400, then 18'h3FFFF with song_done=1.
- 10 ascending entries; no pops for 20 cycles -> exactly DEPTH=4 entries fetched and rom_addr=4. Pop every cycle thereafter -> the bench sees all 10 values in order, with no drop or duplicate.
- Pop on the exact cycle a fetched word is pushed while the FIFO is full -> count stays 4 and sequence order is preserved.
- Mid-song song_start after 3 pops, with a read in flight -> the next visible head is ROM[0]=100 three cycles later, and the stale in-flight value never appears.
- ROM = {500, 300, NOTE_NONE} -> order_error=1 after 300 is pushed and both notes are still delivered. A following song_start leaves order_error=1; reset clears it.
- note_request while empty in IDLE and in DRAIN -> no state change, note_time stays 18'h3FFFF; ROM with no sentinel at ADDR_W=3 -> 8 entries delivered, then song_done=1.
